// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types used by the front end: machine word, fetch-buffer entry
// and the canonical NOP encoding.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  fault;
    } fb_entry_t;

    // addi x0, x0, 0
    localparam word_t RV32_NOP = 32'h0000_0013;

    function automatic fb_entry_t pack_entry(input word_t instr, input word_t pc, input logic fault);
        fb_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/fetch_buffer_checker.sv
// Protocol checker for fetch_buffer: handshake legality and occupancy bound.
module fetch_buffer_checker #(
    parameter int unsigned DEPTH = 4
) (
    input logic                   CLK,
    input logic                   RST,
    input logic                   enq_valid,
    input logic                   enq_ready,
    input logic                   deq_valid,
    input logic                   deq_ready,
    input logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Sampled at each active edge outside reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(enq_valid && enq_ready && (count == CW'(DEPTH))))
                else $error("fetch_buffer_checker: enqueue accepted while full");
            assert (!(deq_valid && deq_ready && (count == CW'(0))))
                else $error("fetch_buffer_checker: dequeue accepted while empty");
            assert (count <= CW'(DEPTH))
                else $error("fetch_buffer_checker: count %0d exceeds depth", count);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: circular buffer of fetched
// words with PC and fault flag, single-cycle flush on redirect.
module fetch_buffer
    import rv32i_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = RV32_NOP
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [31:0]            enq_instr,
    input  logic [31:0]            enq_pc,
    input  logic                   enq_fault,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_instr,
    output logic [31:0]            deq_pc,
    output logic                   deq_fault,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = PW - 1;

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    fb_entry_t     mem_r [DEPTH];

    logic          empty_s;
    logic          full_s;
    logic          enq_fire_s;
    logic          deq_fire_s;
    fb_entry_t     head_s;

    // Occupancy flags and handshakes; the extra wrap bit separates full from empty.
    always_comb begin
        empty_s    = (rd_ptr_r == wr_ptr_r);
        full_s     = (rd_ptr_r[IW-1:0] == wr_ptr_r[IW-1:0]) &&
                     (rd_ptr_r[PW-1] != wr_ptr_r[PW-1]);
        enq_ready  = !full_s && !RST;
        deq_valid  = !empty_s;
        enq_fire_s = enq_valid && enq_ready;
        deq_fire_s = deq_valid && deq_ready;
        count      = wr_ptr_r - rd_ptr_r;
    end

    // Head entry to decode; an empty queue shows a NOP regardless of stale storage.
    always_comb begin
        head_s = mem_r[rd_ptr_r[IW-1:0]];
        if (empty_s) begin
            deq_instr = NOP;
            deq_pc    = 32'h0000_0000;
            deq_fault = 1'b0;
        end else begin
            deq_instr = head_s.instr;
            deq_pc    = head_s.pc;
            deq_fault = head_s.fault;
        end
    end

    // Read/write pointers; flush overrides any handshake in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Entry storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (enq_fire_s && !flush) begin
            mem_r[wr_ptr_r[IW-1:0]] <= pack_entry(enq_instr, enq_pc, enq_fault);
        end
    end

endmodule
